inst_encoder: RTL

Instruction encoder and program loader for the single-cycle CPU: accepts ALU-level operation requests (4-bit ALU opcode plus register numbers), packs each into a 32-bit MIPS R-type word using the same func/ALU_OP mapping the CPU decoder uses, and writes the words sequentially into instruction memory. A small FIFO decouples the request handshake from a memory port that may stall. It sits between the test/program-loading front end and the instruction memory write port.

---
 rtl/inst_encoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - ALU-op to MIPS R-type encoder and sequential instruction memory loader
//
// Packs {alu_op, rs, rt, rd} requests into {6'b0, rs, rt, rd, 5'b0, func}
// words, buffers them in a small FIFO and writes them to consecutive
// instruction memory addresses starting at 0 after each start pulse.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, finish             run control pulses
//   in_valid/in_ready         request handshake; in_nop, alu_op, rs, rt, rd payload
//   mem_ready                 memory accepts a write this cycle
//   mem_we/mem_addr/mem_wdata memory write port
//   err                       one-cycle pulse after an illegal alu_op was dropped
//   done                      high while in DONE
//   word_cnt                  words written since the last start
module inst_encoder #(
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_nop,
    input  logic [3:0]        alu_op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CAP   = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    logic [5:0]  func;
    logic        legal;
    logic [31:0] enc_word;
    logic        fifo_empty;
    logic        fifo_full;
    logic        active;
    logic        room_ok;
    logic        accept;
    logic        push;
    logic [ADDR_W:0] cnt_after;

    // Same func mapping the CPU decoder uses to derive ALU_OP.
    always_comb begin
        func  = 6'b000000;
        legal = 1'b1;
        case (alu_op)
            4'b0100: func = 6'b100000;
            4'b0101: func = 6'b100010;
            4'b0000: func = 6'b100100;
            4'b0001: func = 6'b100101;
            4'b0010: func = 6'b100110;
            4'b0011: func = 6'b100111;
            4'b0110: func = 6'b101011;
            4'b0111: func = 6'b000100;
            default: legal = 1'b0;
        endcase
    end

    assign enc_word   = in_nop ? 32'h0000_0000 : {6'b000000, rs, rt, rd, 5'b00000, func};
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign active     = (state == S_RUN) || (state == S_DRAIN);

    assign mem_we    = !fifo_empty && mem_ready && active;
    assign mem_wdata = fifo_empty ? 32'h0000_0000 : fifo_mem[rd_ptr];
    // Writes never exceed capacity within a run, so the low bits of the
    // written-word count are the next address.
    assign mem_addr  = word_cnt[ADDR_W-1:0];
    assign done      = (state == S_DONE);

    // Words already written plus words queued must stay below capacity.
    assign room_ok  = (32'(word_cnt) + 32'(fifo_cnt)) < 32'(CAP);
    // A full FIFO can still take a word when the head pops in the same cycle.
    assign in_ready = (state == S_RUN) && (!fifo_full || mem_we) && room_ok && !finish;
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_nop || legal);

    assign cnt_after = word_cnt + {{ADDR_W{1'b0}}, mem_we};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            word_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= accept && !push;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mem_we) begin
                rd_ptr   <= rd_ptr + 1'b1;
                word_cnt <= cnt_after;
            end
            case ({push, mem_we})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        word_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (cnt_after == (ADDR_W+1)'(CAP)) begin
                        state <= S_DONE;
                    end else if (finish) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave as soon as the last buffered word is written.
                    if (fifo_empty || (fifo_cnt == CNT_W'(1) && mem_we)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state    <= S_RUN;
                        word_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
